// File: rtl/switch_arbiter_pkg.sv
// Shared constants, state encoding and pointer helper for the per-output switch allocator.
// Optional build macro used by switch_arbiter: SWITCH_ARB_WATCHDOG_EN.
package switch_arbiter_pkg;

    localparam int NUM_PORTS = 5;
    localparam int OWNER_W   = 3;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_S = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin successor of a port index, wrapping at n-1.
    function automatic logic [2:0] next_port(input logic [2:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return 3'd0;
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/switch_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module switch_arbiter_rr_pick #(
    parameter int NUM_PORTS = switch_arbiter_pkg::NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [2:0]           i_ptr,
    output logic [NUM_PORTS-1:0] o_onehot,
    output logic [2:0]           o_idx,
    output logic                 o_found
);

    logic [3:0] w_pos;

    always_comb begin
        o_onehot = '0;
        o_idx    = 3'd0;
        o_found  = 1'b0;
        w_pos    = 4'd0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_pos = {1'b0, i_ptr} + 4'(k);
            if (w_pos >= 4'(NUM_PORTS)) begin
                w_pos = w_pos - 4'(NUM_PORTS);
            end
            if (!o_found && i_req[w_pos[2:0]]) begin
                o_found            = 1'b1;
                o_idx              = w_pos[2:0];
                o_onehot[w_pos[2:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_arbiter.sv
// Per-output switch allocator: round-robin arbitration among head flits, wormhole lock until tail.
// Define SWITCH_ARB_WATCHDOG_EN to add the stall watchdog that force-releases a starved lock.
module switch_arbiter #(
    parameter int NUM_PORTS = switch_arbiter_pkg::NUM_PORTS
`ifdef SWITCH_ARB_WATCHDOG_EN
    , parameter int WDOG_LIMIT = 64
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [NUM_PORTS-1:0] i_head,
    input  logic [NUM_PORTS-1:0] i_tail,
    input  logic                 i_out_ready,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [NUM_PORTS-1:0] o_read_en,
    output logic                 o_write_en,
    output logic [2:0]           o_owner,
    output logic                 o_busy,
    output logic                 o_abort,
    output logic                 o_state
);

    import switch_arbiter_pkg::*;

    arb_state_e           r_state, w_state_nxt;
    logic [2:0]           r_owner, w_owner_nxt;
    logic [2:0]           r_ptr, w_ptr_nxt;
    logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;

    logic [NUM_PORTS-1:0] w_cand;
    logic [NUM_PORTS-1:0] w_pick_onehot;
    logic [2:0]           w_pick_idx;
    logic                 w_pick_found;
    logic                 w_xfer;
    logic                 w_abort;

    assign w_cand = i_req & i_head;

    switch_arbiter_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .i_req    (w_cand),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_found  (w_pick_found)
    );

    // Handshake: a flit moves in a LOCKED cycle where the owner's req (valid) and
    // out_ready (ready) are both high; read_en/write_en strobe exactly that cycle.
    assign w_xfer = (r_state == ST_LOCKED) && i_req[r_owner] && i_out_ready;

`ifdef SWITCH_ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              w_stall;

    // Only an absent owner flit counts as a stall; output back-pressure never does.
    assign w_stall = (r_state == ST_LOCKED) && !i_req[r_owner] && i_out_ready;
    assign w_abort = w_stall && (r_wdog == WDOG_W'(WDOG_LIMIT - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wdog <= '0;
        end else if ((r_state != ST_LOCKED) || w_xfer || w_abort) begin
            r_wdog <= '0;
        end else if (w_stall) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_owner <= 3'd0;
            r_ptr   <= 3'd0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_pick_idx;
                    w_grant_nxt = w_pick_onehot;
                end
            end
            ST_LOCKED: begin
                // The pointer moves only when a lock ends, so arbitration alone never skips anyone.
                if ((w_xfer && i_tail[r_owner]) || w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = next_port(r_owner, NUM_PORTS);
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign o_grant    = r_grant;
    assign o_read_en  = w_xfer ? r_grant : '0;
    assign o_write_en = w_xfer;
    assign o_owner    = r_owner;
    assign o_busy     = (r_state == ST_LOCKED);
    assign o_abort    = w_abort;
    assign o_state    = r_state;

endmodule
